// File: rtl/rv_ifetch_pkg.sv
// Shared constants for the instruction fetch stage: data width, the canonical NOP and PC alignment.
package rv_ifetch_pkg;

  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] NOP_INST        = 32'h0000_0013;
  localparam logic [DATA_WIDTH-1:0] INST_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [DATA_WIDTH-1:0] align_pc(input logic [DATA_WIDTH-1:0] pc);
    return pc & INST_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// Synchronous fetch queue holding {pc, inst} pairs; flush empties it and overrides push/pop.
module rv_fetch_fifo #(
  parameter int          WIDTH   = 64,
  parameter int          DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push & ~flush;
  assign do_pop_s  = pop & ~flush & (count_r != {CW{1'b0}});

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= RST_VAL;
      end
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign empty = (count_r == {CW{1'b0}});
  assign full  = (count_r == CW'(DEPTH));
  assign count = count_r;

endmodule

// File: rtl/rv_ifetch_chk.sv
// Invariant checks for rv_ifetch: queue never overflows, in-flight and drop counters stay in range.
module rv_ifetch_chk #(
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int OW              = 2,
  parameter int CW              = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          push,
  input logic          full,
  input logic          fire,
  input logic          rvalid,
  input logic [OW-1:0] outstanding,
  input logic [OW-1:0] drop_cnt,
  input logic [CW-1:0] count
);

  a_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_out_ovf:   assert property (@(posedge clk) disable iff (rst)
                 !(fire && !rvalid && outstanding == OW'(MAX_OUTSTANDING)));
  a_out_udf:   assert property (@(posedge clk) disable iff (rst) !(rvalid && outstanding == {OW{1'b0}}));
  a_drop_rng:  assert property (@(posedge clk) disable iff (rst) drop_cnt <= outstanding);
  a_cnt_rng:   assert property (@(posedge clk) disable iff (rst) count <= CW'(FIFO_DEPTH));

endmodule

// File: rtl/rv_ifetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited imem reads and queues {pc, inst} for decode.
module rv_ifetch import rv_ifetch_pkg::*; #(
  parameter logic [DATA_WIDTH-1:0] RESET_PC        = 32'h0000_0000,
  parameter int                    FIFO_DEPTH      = 2,
  parameter int                    MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_inst,
  output logic [DATA_WIDTH-1:0] id_pc
);

  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int EW = 2*DATA_WIDTH;

  logic [DATA_WIDTH-1:0] pc_r;
  logic [DATA_WIDTH-1:0] ret_pc_r;
  logic [OW-1:0]         outstanding_r;
  logic [OW-1:0]         drop_cnt_r;
  logic [OW-1:0]         outstanding_next_s;
  logic [CW-1:0]         fifo_count_s;
  logic [EW-1:0]         fifo_dout_s;
  logic [DATA_WIDTH-1:0] target_s;
  logic [7:0]            occupancy_s;
  logic                  fifo_empty_s;
  logic                  fifo_full_s;
  logic                  credit_ok_s;
  logic                  fire_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  drop_s;

  assign target_s = align_pc(redirect_pc);
  assign pop_s    = ~fifo_empty_s & id_ready;

  // A slot freed by this cycle's pop may be promised to a new request, keeping one inst/cycle.
  assign occupancy_s = 8'(outstanding_r) + 8'(fifo_count_s) - 8'(pop_s);
  assign credit_ok_s = (outstanding_r < OW'(MAX_OUTSTANDING)) & (occupancy_s < 8'(FIFO_DEPTH));

  assign imem_req  = ~rst & credit_ok_s;
  assign imem_addr = pc_r;
  assign fire_s    = imem_req & imem_gnt;

  assign drop_s = imem_rvalid & (drop_cnt_r != {OW{1'b0}});
  assign push_s = imem_rvalid & (drop_cnt_r == {OW{1'b0}}) & ~redirect_valid;

  assign outstanding_next_s = outstanding_r + OW'(fire_s) - OW'(imem_rvalid);

  // PC, return-PC and in-flight bookkeeping; on redirect every request still in flight becomes stale
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      ret_pc_r      <= RESET_PC;
      outstanding_r <= {OW{1'b0}};
      drop_cnt_r    <= {OW{1'b0}};
    end else begin
      outstanding_r <= outstanding_next_s;
      if (redirect_valid) begin
        pc_r       <= target_s;
        ret_pc_r   <= target_s;
        drop_cnt_r <= outstanding_next_s;
      end else begin
        if (fire_s) begin
          pc_r <= pc_r + 32'd4;
        end
        if (push_s) begin
          ret_pc_r <= ret_pc_r + 32'd4;
        end
        if (drop_s) begin
          drop_cnt_r <= drop_cnt_r - OW'(1);
        end
      end
    end
  end

  rv_fetch_fifo #(
    .WIDTH   (EW),
    .DEPTH   (FIFO_DEPTH),
    .RST_VAL ({RESET_PC, NOP_INST})
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({ret_pc_r, imem_rdata}),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s),
    .count (fifo_count_s)
  );

  assign id_valid = ~fifo_empty_s;
  assign id_pc    = fifo_dout_s[EW-1:DATA_WIDTH];
  assign id_inst  = fifo_dout_s[DATA_WIDTH-1:0];

  rv_ifetch_chk #(
    .FIFO_DEPTH      (FIFO_DEPTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .OW              (OW),
    .CW              (CW)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .push        (push_s),
    .full        (fifo_full_s),
    .fire        (fire_s),
    .rvalid      (imem_rvalid),
    .outstanding (outstanding_r),
    .drop_cnt    (drop_cnt_r),
    .count       (fifo_count_s)
  );

endmodule

// File: tb/tb_rv_ifetch.sv
// Scoreboard bench for rv_ifetch: in-order imem model, expected {pc, inst} stream queued at grant time.
module tb_rv_ifetch;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  rv_ifetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst),
    .id_pc(id_pc)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } exp_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  logic [31:0] fpc;
  int          cyc = 0;
  int          pops = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          checks = 0;
  int          errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0001_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // One cycle: drive inputs at the falling edge, then update the reference model for the next rising edge.
  task automatic step(input bit r, input bit g, input bit rdy, input bit rd, input logic [31:0] rpc);
    rst = r; imem_gnt = g; id_ready = rdy; redirect_valid = rd; redirect_pc = rpc;
    if (!r && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    #3;
    if (r) begin
      pend_q.delete();
      exp_q.delete();
      fpc = RESET_PC;
    end else begin
      if (id_valid === 1'b1 && rdy && !rd) pops++;
      if (imem_rvalid) void'(pend_q.pop_front());
      if (imem_req === 1'b1 && g) begin
        pend_q.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
        if (!rd) exp_q.push_back('{pc: fpc, inst: mem_word(fpc)});
        fpc = fpc + 32'd4;
      end
      if (rd) begin
        exp_q.delete();
        fpc = rpc & 32'hFFFF_FFFC;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_check_first(input logic [31:0] tgt, input int n);
    bit seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!seen && id_valid === 1'b1) begin
        chk("first_pc_after_redirect", id_pc, tgt);
        seen = 1'b1;
      end
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL first_pc_after_redirect actual=no_output required=%h", tgt);
    end
  endtask

  // Monitor: address check on every request, scoreboard pop on every accepted decode handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b1) begin
        chk("req_during_rst", {31'd0, imem_req}, 32'd0);
      end else begin
        if (imem_req === 1'b1) chk("imem_addr", imem_addr, fpc);
        if (id_valid === 1'b1 && id_ready === 1'b1 && redirect_valid === 1'b0) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output actual=%h required=none", id_pc);
          end else begin
            e = exp_q.pop_front();
            chk("id_pc", id_pc, e.pc);
            chk("id_inst", id_inst, e.inst);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int fv;
    bit r, g, rdy, rd;
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0; fpc = RESET_PC;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_id_inst", id_inst, NOP);
    chk("rst_id_pc", id_pc, RESET_PC);

    // Streaming with single-cycle memory latency
    lat_min = 1; lat_max = 1; pops = 0; fv = -1; c0 = cyc;
    for (int i = 0; i < 20; i++) begin
      if (fv < 0 && id_valid === 1'b1) fv = cyc - c0;
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    end
    chk("first_valid_latency", fv, 32'd2);
    chk("steady_throughput", pops, 32'd18);

    // Decode stall: queue fills, issue stops, head stays put
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      if (i >= 3) begin
        chk("stall_req", {31'd0, imem_req}, 32'd0);
        chk("stall_valid", {31'd0, id_valid}, 32'd1);
        if (exp_q.size() > 0) begin
          chk("stall_pc", id_pc, exp_q[0].pc);
          chk("stall_inst", id_inst, exp_q[0].inst);
        end
      end
    end
    pops = 0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("stall_drain_count", pops, FIFO_DEPTH);
    chk("drain_empty", {31'd0, id_valid}, 32'd0);

    // Redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && pend_q.size() < 2; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    if (pend_q.size() < 2) begin
      checks++; errors++;
      $display("FAIL two_outstanding actual=%0d required=2", pend_q.size());
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0102);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    chk("redir_bubble_valid", {31'd0, id_valid}, 32'd0);
    run_check_first(32'h0000_0100, 16);

    // Redirect coinciding with a response and a grant
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("collide_rvalid", {31'd0, imem_rvalid}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_2000);
    run_check_first(32'h0000_2000, 12);

    // Grant held off, then fetch across the top of the address space
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
    for (int i = 0; i < 5; i++) begin
      chk("hold_req", {31'd0, imem_req}, 32'd1);
      chk("hold_addr", imem_addr, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Reset with work queued and in flight
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_valid", {31'd0, id_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, RESET_PC);

    // Randomised traffic
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(999, 0) < 3);
      g   = ($urandom_range(9, 0) < 7);
      rdy = ($urandom_range(9, 0) < 7);
      rd  = !r && ($urandom_range(99, 0) < 5);
      step(r, g, rdy, rd, $urandom());
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("final_all_delivered", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
